// File: rtl/adder_axil_pkg.sv
// Shared definitions for the adder AXI4-Lite master and the adder slave:
// sequencer states, default register offsets and response encodings.
package adder_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR_A  = 3'd1,
        ST_WB_A  = 3'd2,
        ST_WR_B  = 3'd3,
        ST_WB_B  = 3'd4,
        ST_RD    = 3'd5,
        ST_WR_RD = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    localparam logic [7:0] OPA_OFFSET = 8'h00;
    localparam logic [7:0] OPB_OFFSET = 8'h04;
    localparam logic [7:0] RES_OFFSET = 8'h08;

    localparam logic AXI_RESP_OK  = 1'b0;
    localparam logic AXI_RESP_ERR = 1'b1;

    // States in which the sequencer is waiting on the slave and the watchdog runs.
    function automatic logic is_wait_state(input state_e s);
        logic w;
        case (s)
            ST_WR_A, ST_WB_A, ST_WR_B, ST_WB_B, ST_RD, ST_WR_RD: w = 1'b1;
            default:                                             w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/axil_write_channel.sv
// One AXI4-Lite write (AW + W + B). AW and W complete independently; bready is
// raised once both have been accepted and the write finishes on the B beat.
module axil_write_channel
    import adder_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    addr_done_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic                    bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o
);

    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  addr_done_s;
    logic                  done_s;

    // Next-state of the three channel valids/readies and the held address/data.
    always_comb begin
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        addr_done_s = (awvalid_q | wvalid_q) & (~awvalid_q | awready_i) & (~wvalid_q | wready_i);
        done_s      = bready_q & bvalid_i;
        if (abort_i) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
        end else if (start_i) begin
            awaddr_d  = addr_i;
            wdata_d   = data_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b0;
        end else begin
            awvalid_d = awvalid_q & ~awready_i;
            wvalid_d  = wvalid_q & ~wready_i;
            if (addr_done_s) begin
                bready_d = 1'b1;
            end else if (done_s) begin
                bready_d = 1'b0;
            end else begin
                bready_d = bready_q;
            end
        end
    end

    // Channel register bank.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            awaddr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign addr_done_o = addr_done_s;
    assign done_o      = done_s;
    assign err_o       = done_s & (bresp_i == AXI_RESP_ERR);
    assign awaddr_o    = awaddr_q;
    assign awvalid_o   = awvalid_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = {(DATA_WIDTH/8){1'b1}};
    assign wvalid_o    = wvalid_q;
    assign bready_o    = bready_q;

endmodule

// File: rtl/adder_axil_master.sv
// AXI4-Lite master for the adder: writes op_a and op_b, reads back the result
// and returns it with a sticky error flag. One request in flight at a time.
module adder_axil_master
    import adder_axil_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] OPA_ADDR       = ADDR_WIDTH'(OPA_OFFSET),
    parameter logic [ADDR_WIDTH-1:0] OPB_ADDR       = ADDR_WIDTH'(OPB_OFFSET),
    parameter logic [ADDR_WIDTH-1:0] RES_ADDR       = ADDR_WIDTH'(RES_OFFSET),
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_aresetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH-1:0]   req_op_a,
    input  logic [DATA_WIDTH-1:0]   req_op_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    res_err,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic                    m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic                    m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);

    // The counter only has to reach TIMEOUT_CYCLES-1 before the watchdog fires.
    localparam int             WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);

    state_e                state_q, state_d, state_nxt_s;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic                  err_q, err_d;
    logic                  res_valid_q, res_valid_d;
    logic                  req_ready_q, req_ready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;

    logic                  accept_s;
    logic                  wc_start_s;
    logic                  wc_addr_done_s;
    logic                  wc_done_s;
    logic                  wc_err_s;
    logic                  rd_done_s;
    logic                  in_wait_s;
    logic                  timeout_s;
    logic [ADDR_WIDTH-1:0] wc_addr_s;
    logic [DATA_WIDTH-1:0] wc_data_s;

    // Operand A goes straight from the request port into the write channel so
    // AW/W can rise on the cycle after accept; only operand B needs holding.
    assign wc_addr_s = (state_q == ST_IDLE) ? OPA_ADDR : OPB_ADDR;
    assign wc_data_s = (state_q == ST_IDLE) ? req_op_a : op_b_q;

    axil_write_channel #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr (
        .clk_i       (m1_axi_aclk),
        .rst_ni      (m1_axi_aresetn),
        .start_i     (wc_start_s),
        .abort_i     (timeout_s),
        .addr_i      (wc_addr_s),
        .data_i      (wc_data_s),
        .addr_done_o (wc_addr_done_s),
        .done_o      (wc_done_s),
        .err_o       (wc_err_s),
        .awaddr_o    (m1_axi_awaddr),
        .awvalid_o   (m1_axi_awvalid),
        .awready_i   (m1_axi_awready),
        .wdata_o     (m1_axi_wdata),
        .wstrb_o     (m1_axi_wstrb),
        .wvalid_o    (m1_axi_wvalid),
        .wready_i    (m1_axi_wready),
        .bresp_i     (m1_axi_bresp),
        .bvalid_i    (m1_axi_bvalid),
        .bready_o    (m1_axi_bready)
    );

    // Sequencer next state from handshakes, with the watchdog able to force DONE.
    always_comb begin
        state_nxt_s = state_q;
        accept_s    = 1'b0;
        wc_start_s  = 1'b0;
        rd_done_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_nxt_s = ST_WR_A;
                    accept_s    = 1'b1;
                    wc_start_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_A:  state_nxt_s = wc_addr_done_s ? ST_WB_A : ST_WR_A;
            ST_WB_A: begin
                if (wc_done_s) begin
                    state_nxt_s = ST_WR_B;
                    wc_start_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_WB_A;
                end
            end
            ST_WR_B:  state_nxt_s = wc_addr_done_s ? ST_WB_B : ST_WR_B;
            ST_WB_B:  state_nxt_s = wc_done_s ? ST_RD : ST_WB_B;
            ST_RD:    state_nxt_s = (arvalid_q && m1_axi_arready) ? ST_WR_RD : ST_RD;
            ST_WR_RD: begin
                if (rready_q && m1_axi_rvalid) begin
                    state_nxt_s = ST_DONE;
                    rd_done_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WR_RD;
                end
            end
            ST_DONE:  state_nxt_s = res_ready ? ST_IDLE : ST_DONE;
            default:  state_nxt_s = ST_IDLE;
        endcase
        in_wait_s = is_wait_state(state_q);
        timeout_s = WD_EN && in_wait_s && (state_nxt_s == state_q) && (wd_cnt_q == WD_LAST);
    end

    // Datapath and registered-output next values.
    always_comb begin
        state_d     = timeout_s ? ST_DONE : state_nxt_s;
        wd_cnt_d    = ((state_d != state_q) || !in_wait_s) ? {WD_W{1'b0}} : (wd_cnt_q + WD_W'(1));
        op_b_d      = accept_s ? req_op_b : op_b_q;
        res_data_d  = rd_done_s ? m1_axi_rdata : res_data_q;
        araddr_d    = (state_d == ST_RD) ? RES_ADDR : araddr_q;
        arvalid_d   = (state_d == ST_RD);
        rready_d    = (state_d == ST_WR_RD);
        res_valid_d = (state_d == ST_DONE);
        req_ready_d = (state_d == ST_IDLE);
        if (accept_s) begin
            err_d = 1'b0;
        end else if (timeout_s) begin
            err_d = 1'b1;
        end else if (wc_err_s) begin
            err_d = 1'b1;
        end else if (rd_done_s && (m1_axi_rresp == AXI_RESP_ERR)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Sequencer, watchdog and output registers.
    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            state_q     <= ST_IDLE;
            wd_cnt_q    <= {WD_W{1'b0}};
            op_b_q      <= {DATA_WIDTH{1'b0}};
            res_data_q  <= {DATA_WIDTH{1'b0}};
            araddr_q    <= {ADDR_WIDTH{1'b0}};
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_cnt_q    <= wd_cnt_d;
            op_b_q      <= op_b_d;
            res_data_q  <= res_data_d;
            araddr_q    <= araddr_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            req_ready_q <= req_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_err        = err_q;
    assign m1_axi_araddr  = araddr_q;
    assign m1_axi_arvalid = arvalid_q;
    assign m1_axi_rready  = rready_q;

endmodule

// File: tb/tb_adder_axil_master.sv
// Bench for adder_axil_master: an adder slave on the AXI side with programmable
// ready delays and error injection, and a result model computed from the operands.
module tb_adder_axil_master;

    localparam int TMO = 16;

    logic        m1_axi_aclk;
    logic        m1_axi_aresetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_op_a;
    logic [31:0] req_op_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic [7:0]  m1_axi_awaddr;
    logic        m1_axi_awvalid;
    logic        m1_axi_awready;
    logic [31:0] m1_axi_wdata;
    logic [3:0]  m1_axi_wstrb;
    logic        m1_axi_wvalid;
    logic        m1_axi_wready;
    logic        m1_axi_bresp;
    logic        m1_axi_bvalid;
    logic        m1_axi_bready;
    logic [7:0]  m1_axi_araddr;
    logic        m1_axi_arvalid;
    logic        m1_axi_arready;
    logic [31:0] m1_axi_rdata;
    logic        m1_axi_rresp;
    logic        m1_axi_rvalid;
    logic        m1_axi_rready;

    adder_axil_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .m1_axi_aclk    (m1_axi_aclk),
        .m1_axi_aresetn (m1_axi_aresetn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op_a       (req_op_a),
        .req_op_b       (req_op_b),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_err        (res_err),
        .m1_axi_awaddr  (m1_axi_awaddr),
        .m1_axi_awvalid (m1_axi_awvalid),
        .m1_axi_awready (m1_axi_awready),
        .m1_axi_wdata   (m1_axi_wdata),
        .m1_axi_wstrb   (m1_axi_wstrb),
        .m1_axi_wvalid  (m1_axi_wvalid),
        .m1_axi_wready  (m1_axi_wready),
        .m1_axi_bresp   (m1_axi_bresp),
        .m1_axi_bvalid  (m1_axi_bvalid),
        .m1_axi_bready  (m1_axi_bready),
        .m1_axi_araddr  (m1_axi_araddr),
        .m1_axi_arvalid (m1_axi_arvalid),
        .m1_axi_arready (m1_axi_arready),
        .m1_axi_rdata   (m1_axi_rdata),
        .m1_axi_rresp   (m1_axi_rresp),
        .m1_axi_rvalid  (m1_axi_rvalid),
        .m1_axi_rready  (m1_axi_rready)
    );

    initial m1_axi_aclk = 1'b0;
    always #5 m1_axi_aclk = ~m1_axi_aclk;

    int checks = 0;
    int errors = 0;

    // Slave configuration and state
    int          aw_lat = 0, w_lat = 0, aw_cnt = 0, w_cnt = 0;
    bit          ar_never = 1'b0, berr_a = 1'b0, berr_b = 1'b0, rerr = 1'b0;
    bit          have_aw = 1'b0, have_w = 1'b0;
    logic [7:0]  p_addr;
    logic [31:0] p_data, reg_a = 32'd0, reg_b = 32'd0;
    logic [7:0]  wlog_addr[$];
    logic [31:0] wlog_data[$];
    int          rd_count = 0;
    logic [7:0]  rd_addr = 8'd0;
    int          aw_hi = 0, w_hi = 0, ar_hi = 0;
    logic [45:0] first_beat;
    logic [31:0] last_sum = 32'd0;

    assign m1_axi_awready = (aw_cnt >= aw_lat);
    assign m1_axi_wready  = (w_cnt >= w_lat);
    assign m1_axi_arready = !ar_never;

    always @(posedge m1_axi_aclk) begin
        if (!m1_axi_aresetn) begin
            aw_cnt <= 0; w_cnt <= 0;
            m1_axi_bvalid <= 1'b0; m1_axi_bresp <= 1'b0;
            m1_axi_rvalid <= 1'b0; m1_axi_rresp <= 1'b0; m1_axi_rdata <= 32'd0;
            have_aw = 1'b0; have_w = 1'b0;
        end else begin
            aw_cnt <= (m1_axi_awvalid && !m1_axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m1_axi_wvalid && !m1_axi_wready) ? w_cnt + 1 : 0;
            if (m1_axi_awvalid && m1_axi_awready) begin have_aw = 1'b1; p_addr = m1_axi_awaddr; end
            if (m1_axi_wvalid && m1_axi_wready) begin have_w = 1'b1; p_data = m1_axi_wdata; end
            if (m1_axi_bvalid && m1_axi_bready) m1_axi_bvalid <= 1'b0;
            if (have_aw && have_w) begin
                wlog_addr.push_back(p_addr);
                wlog_data.push_back(p_data);
                if (p_addr == 8'h00) reg_a = p_data;
                if (p_addr == 8'h04) reg_b = p_data;
                m1_axi_bvalid <= 1'b1;
                m1_axi_bresp  <= (p_addr == 8'h04) ? berr_b : berr_a;
                have_aw = 1'b0; have_w = 1'b0;
            end
            if (m1_axi_rvalid && m1_axi_rready) m1_axi_rvalid <= 1'b0;
            if (m1_axi_arvalid && m1_axi_arready) begin
                rd_count = rd_count + 1;
                rd_addr  = m1_axi_araddr;
                m1_axi_rvalid <= 1'b1;
                m1_axi_rdata  <= reg_a + reg_b;
                m1_axi_rresp  <= rerr;
            end
        end
    end

    always @(negedge m1_axi_aclk) begin
        if (m1_axi_aresetn) begin
            aw_hi = aw_hi + int'(m1_axi_awvalid);
            w_hi  = w_hi + int'(m1_axi_wvalid);
            ar_hi = ar_hi + int'(m1_axi_arvalid);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns cycles from accept until res_valid is seen.
    task automatic do_req(input logic [31:0] a, input logic [31:0] b, output int lat);
        int n;
        @(negedge m1_axi_aclk); #1;
        aw_hi = 0; w_hi = 0; ar_hi = 0; rd_count = 0;
        wlog_addr.delete(); wlog_data.delete();
        req_valid = 1'b1; req_op_a = a; req_op_b = b;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge m1_axi_aclk); #1; n++; end
        chk("accept_ready", req_ready, 1);
        @(posedge m1_axi_aclk);
        @(negedge m1_axi_aclk);
        first_beat = {m1_axi_awvalid, m1_axi_wvalid, m1_axi_awaddr, m1_axi_wdata, m1_axi_wstrb};
        #1;
        req_valid = 1'b0; req_op_a = $urandom; req_op_b = $urandom;
        lat = 1;
        while (res_valid !== 1'b1 && lat < 300) begin @(negedge m1_axi_aclk); lat++; end
        chk("res_valid_seen", res_valid, 1);
    endtask

    task automatic check_txn(input logic [31:0] a, input logic [31:0] b, input bit exp_err,
                             input int lat, input int law, input int lw);
        logic [31:0] sum;
        int          mx;
        sum = a + b;
        mx  = (law > lw) ? law : lw;
        chk("res_data", res_data, sum);
        chk("res_err", res_err, exp_err);
        chk("latency", lat, 2 * mx + 7);
        chk("first_beat", first_beat, {1'b1, 1'b1, 8'h00, a, 4'hF});
        chk("aw_cycles", aw_hi, 2 * (law + 1));
        chk("w_cycles", w_hi, 2 * (lw + 1));
        chk("ar_cycles", ar_hi, 1);
        chk("write_count", wlog_addr.size(), 2);
        if (wlog_addr.size() == 2) begin
            chk("write0", {wlog_addr[0], wlog_data[0]}, {8'h00, a});
            chk("write1", {wlog_addr[1], wlog_data[1]}, {8'h04, b});
        end
        chk("read_count", rd_count, 1);
        chk("read_addr", rd_addr, 8'h08);
        last_sum = sum;
    endtask

    task automatic finish_res();
        #1 res_ready = 1'b1;
        @(posedge m1_axi_aclk); #1;
        res_ready = 1'b0;
        @(negedge m1_axi_aclk);
        chk("res_valid_drop", res_valid, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ctl", {req_ready, res_valid, res_err, m1_axi_awvalid, m1_axi_wvalid,
                        m1_axi_bready, m1_axi_arvalid, m1_axi_rready}, 8'h00);
        chk("rst_res_data", res_data, 0);
        chk("rst_wdata", m1_axi_wdata, 0);
        chk("rst_addr", {m1_axi_awaddr, m1_axi_araddr}, 0);
    endtask

    initial begin
        int          lat;
        logic [31:0] a, b, held;
        bit          stable, e;
        m1_axi_aresetn = 1'b0;
        req_valid = 1'b0; req_op_a = 32'd0; req_op_b = 32'd0; res_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge m1_axi_aclk);
        check_reset_outputs();
        m1_axi_aresetn = 1'b1;
        @(negedge m1_axi_aclk);
        chk("idle_ready", req_ready, 1);

        // 1: 39 + 40, zero-wait slave
        do_req(32'd39, 32'd40, lat);
        check_txn(32'd39, 32'd40, 1'b0, lat, 0, 0);
        chk("sum_79", res_data, 32'd79);
        finish_res();

        // 2: W accepted three cycles before AW
        aw_lat = 3; w_lat = 0;
        a = $urandom; b = $urandom;
        do_req(a, b, lat);
        check_txn(a, b, 1'b0, lat, 3, 0);
        finish_res();
        aw_lat = 0;

        // 3: error response on the op_b write
        berr_b = 1'b1;
        a = $urandom; b = $urandom;
        do_req(a, b, lat);
        check_txn(a, b, 1'b1, lat, 0, 0);
        finish_res();
        berr_b = 1'b0;

        // 4: consumer stalls for 10 cycles
        a = $urandom; b = $urandom;
        do_req(a, b, lat);
        check_txn(a, b, 1'b0, lat, 0, 0);
        held = res_data; stable = 1'b1;
        repeat (10) begin
            @(negedge m1_axi_aclk);
            if (!(res_valid === 1'b1 && res_data === held && req_ready === 1'b0)) stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        finish_res();

        // Randomized delays and error injection
        for (int i = 0; i < 6; i++) begin
            aw_lat = $urandom_range(0, 3);
            w_lat  = $urandom_range(0, 3);
            berr_a = ($urandom_range(0, 3) == 0);
            berr_b = ($urandom_range(0, 3) == 0);
            rerr   = ($urandom_range(0, 3) == 0);
            e = berr_a | berr_b | rerr;
            a = $urandom; b = $urandom;
            do_req(a, b, lat);
            check_txn(a, b, e, lat, aw_lat, w_lat);
            finish_res();
        end
        aw_lat = 0; w_lat = 0; berr_a = 1'b0; berr_b = 1'b0; rerr = 1'b0;

        // 5: read address never accepted, watchdog fires
        ar_never = 1'b1;
        held = last_sum;
        do_req($urandom, $urandom, lat);
        chk("tmo_ar_cycles", ar_hi, TMO);
        chk("tmo_latency", lat, TMO + 5);
        chk("tmo_err", res_err, 1);
        chk("tmo_data_kept", res_data, held);
        chk("tmo_axi_idle", {m1_axi_arvalid, m1_axi_rready, m1_axi_awvalid, m1_axi_wvalid, m1_axi_bready}, 5'd0);
        chk("tmo_no_read", rd_count, 0);
        finish_res();
        ar_never = 1'b0;

        // 6: reset while waiting for the op_a write response
        @(negedge m1_axi_aclk); #1;
        req_valid = 1'b1; req_op_a = $urandom; req_op_b = $urandom;
        @(posedge m1_axi_aclk);
        @(negedge m1_axi_aclk); #1;
        req_valid = 1'b0;
        @(negedge m1_axi_aclk);
        chk("wb_a_bready", m1_axi_bready, 1);
        #1 m1_axi_aresetn = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge m1_axi_aclk);
        m1_axi_aresetn = 1'b1;
        @(negedge m1_axi_aclk);
        chk("post_rst_ready", req_ready, 1);
        a = $urandom; b = $urandom;
        do_req(a, b, lat);
        check_txn(a, b, 1'b0, lat, 0, 0);
        finish_res();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
